// File: rtl/load_align_queue_pkg.sv
// Shared types for the memory-stage load return path.
// Decoded load ops, data word and per-load metadata.
package load_align_queue_pkg;

  localparam int LQ_DST_W = 5;

  typedef enum logic [2:0] {
    OP_NOP,
    OP_LB,
    OP_LBU,
    OP_LH,
    OP_LHU,
    OP_LW,
    OP_LWL,
    OP_LWR
  } decoded_op_t;

  typedef logic [31:0] word_t;

  typedef struct packed {
    decoded_op_t         op;
    logic [1:0]          addr_lo;
    logic [LQ_DST_W-1:0] dst;
    word_t               old;
  } load_meta_t;

endpackage

// File: rtl/load_align_queue_extend.sv
// Load data alignment and sign/zero extension.
// Purely combinational; sits on the FIFO head.
module load_extend
  import load_align_queue_pkg::*;
(
  input  decoded_op_t op,
  input  logic [1:0]  addr_lo,
  input  word_t       data,
  input  word_t       old,
  output word_t       res
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;
  word_t       lwl_v;
  word_t       lwr_v;

  assign byte_v = data[8*addr_lo +: 8];
  assign half_v = addr_lo[1] ? data[31:16]
                             : data[15:0];

  always_comb begin
    lwl_v = data;
    lwr_v = data;
    case (addr_lo)
      2'd0: begin
        lwl_v = {data[7:0], old[23:0]};
        lwr_v = data;
      end
      2'd1: begin
        lwl_v = {data[15:0], old[15:0]};
        lwr_v = {old[31:24], data[31:8]};
      end
      2'd2: begin
        lwl_v = {data[23:0], old[7:0]};
        lwr_v = {old[31:16], data[31:16]};
      end
      default: begin
        lwl_v = data;
        lwr_v = {old[31:8], data[31:24]};
      end
    endcase
  end

  always_comb begin
    res = data;
    unique case (op)
      OP_LB:   res = {{24{byte_v[7]}}, byte_v};
      OP_LBU:  res = {24'h0, byte_v};
      OP_LH:   res = {{16{half_v[15]}}, half_v};
      OP_LHU:  res = {16'h0, half_v};
      OP_LWL:  res = lwl_v;
      OP_LWR:  res = lwr_v;
      default: res = data;
    endcase
  end

endmodule

// File: rtl/load_align_queue.sv
// In-order load return queue: pairs dcache beats with
// issued-load metadata and registers the aligned result.
module load_align_queue
  import load_align_queue_pkg::*;
#(
  parameter  int DEPTH = 4,
  parameter  int DST_W = LQ_DST_W,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  decoded_op_t      req_op,
  input  logic [1:0]       req_addr_lo,
  input  logic [DST_W-1:0] req_dst,
  input  logic [31:0]      req_old,
  input  logic             resp_valid,
  output logic             resp_ready,
  input  logic [31:0]      resp_data,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic [31:0]      wb_data,
  output logic [DST_W-1:0] wb_dst,
  output logic             err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int SUM_W = CNT_W + 1;

  logic [PTR_W-1:0] rd_q, rd_d;
  logic [PTR_W-1:0] wr_q, wr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic             wb_valid_q, wb_valid_d;
  word_t            wb_data_q, wb_data_d;
  logic [DST_W-1:0] wb_dst_q, wb_dst_d;
  logic             err_q, err_d;

  load_meta_t       mem_q [DEPTH];
  load_meta_t       head;
  load_meta_t       meta_in;
  word_t            ext;
  logic [SUM_W-1:0] drop_sum;

  logic full, req_fire, resp_fire;
  logic dropping, drop_hit, pop, orphan;

  assign full       = cnt_q == CNT_W'(DEPTH);
  assign dropping   = drop_q != '0;
  assign req_ready  = !full && !flush;
  assign resp_ready = dropping || !wb_valid_q || wb_ready;
  assign req_fire   = req_valid && req_ready;
  assign resp_fire  = resp_valid && resp_ready;
  assign drop_hit   = resp_fire && dropping;
  assign pop        = resp_fire && !dropping
                      && cnt_q != '0;
  assign orphan     = resp_fire && !dropping
                      && cnt_q == '0;

  assign head = mem_q[rd_q];

  assign meta_in.op      = req_op;
  assign meta_in.addr_lo = req_addr_lo;
  assign meta_in.dst     = LQ_DST_W'(req_dst);
  assign meta_in.old     = req_old;

  load_extend u_ext (
    .op      (head.op),
    .addr_lo (head.addr_lo),
    .data    (resp_data),
    .old     (head.old),
    .res     (ext)
  );

  // Loads killed by flush still get a dcache beat; count them out.
  assign drop_sum = SUM_W'(drop_q) + SUM_W'(cnt_q)
                  - SUM_W'(pop) - SUM_W'(drop_hit);

  always_comb begin
    rd_d       = rd_q;
    wr_d       = wr_q;
    cnt_d      = cnt_q;
    drop_d     = drop_q;
    wb_valid_d = wb_valid_q;
    wb_data_d  = wb_data_q;
    wb_dst_d   = wb_dst_q;
    err_d      = err_q || orphan;
    if (flush) begin
      rd_d       = '0;
      wr_d       = '0;
      cnt_d      = '0;
      wb_valid_d = 1'b0;
      if (drop_sum > SUM_W'(DEPTH))
        drop_d = CNT_W'(DEPTH);
      else
        drop_d = drop_sum[CNT_W-1:0];
    end else begin
      if (req_fire)
        wr_d = wr_q + PTR_W'(1);
      if (pop)
        rd_d = rd_q + PTR_W'(1);
      cnt_d = cnt_q + CNT_W'(req_fire)
                    - CNT_W'(pop);
      if (drop_hit)
        drop_d = drop_q - CNT_W'(1);
      if (pop) begin
        wb_valid_d = 1'b1;
        wb_data_d  = ext;
        wb_dst_d   = DST_W'(head.dst);
      end else if (wb_ready) begin
        wb_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_q       <= '0;
      wr_q       <= '0;
      cnt_q      <= '0;
      drop_q     <= '0;
      wb_valid_q <= 1'b0;
      wb_data_q  <= '0;
      wb_dst_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      cnt_q      <= cnt_d;
      drop_q     <= drop_d;
      wb_valid_q <= wb_valid_d;
      wb_data_q  <= wb_data_d;
      wb_dst_q   <= wb_dst_d;
      err_q      <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (req_fire)
      mem_q[wr_q] <= meta_in;
  end

  assign wb_valid = wb_valid_q;
  assign wb_data  = wb_data_q;
  assign wb_dst   = wb_dst_q;
  assign err      = err_q;

endmodule

// File: tb/tb_load_align_queue.sv
// Directed bench for load_align_queue: alignment table
// plus backpressure, flush, orphan and reset sequences.
module tb_load_align_queue;
  import load_align_queue_pkg::*;

  logic        clk;
  logic        resetn;
  logic        flush;
  logic        req_valid;
  logic        req_ready;
  decoded_op_t req_op;
  logic [1:0]  req_addr_lo;
  logic [4:0]  req_dst;
  logic [31:0] req_old;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic        wb_valid;
  logic        wb_ready;
  logic [31:0] wb_data;
  logic [4:0]  wb_dst;
  logic        err;

  int checks;
  int errors;

  load_align_queue dut (
    .clk         (clk),
    .resetn      (resetn),
    .flush       (flush),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_addr_lo (req_addr_lo),
    .req_dst     (req_dst),
    .req_old     (req_old),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_data   (resp_data),
    .wb_valid    (wb_valid),
    .wb_ready    (wb_ready),
    .wb_data     (wb_data),
    .wb_dst      (wb_dst),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct {
    decoded_op_t op;
    logic [1:0]  a;
    logic [31:0] d;
    logic [31:0] o;
    logic [31:0] exp;
  } vec_t;

  localparam int NV = 17;
  vec_t v [NV];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  task automatic push(input decoded_op_t op,
                      input logic [1:0] a,
                      input logic [31:0] o,
                      input logic [4:0] dst);
    @(negedge clk);
    req_valid   = 1'b1;
    req_op      = op;
    req_addr_lo = a;
    req_old     = o;
    req_dst     = dst;
    @(negedge clk);
    req_valid   = 1'b0;
  endtask

  task automatic load_one(input decoded_op_t op,
                          input logic [1:0] a,
                          input logic [31:0] d,
                          input logic [31:0] o,
                          input logic [4:0] dst,
                          input logic [31:0] exp);
    push(op, a, o, dst);
    resp_valid = 1'b1;
    resp_data  = d;
    #1;
    chk("pre_wb_valid", {31'b0, wb_valid}, 32'd0);
    @(negedge clk);
    resp_valid = 1'b0;
    chk("wb_valid", {31'b0, wb_valid}, 32'd1);
    chk("wb_data", wb_data, exp);
    chk("wb_dst", {27'b0, wb_dst}, {27'b0, dst});
  endtask

  task automatic flush_case(input bit with_resp,
                            input int swallow);
    for (int i = 0; i < 3; i++)
      push(OP_LW, 2'd0, 32'h0, 5'(5 + i));
    flush = 1'b1;
    if (with_resp) begin
      resp_valid = 1'b1;
      resp_data  = 32'hDEAD_0000;
    end
    #1;
    chk("flush_req_ready",
        {31'b0, req_ready}, 32'd0);
    @(negedge clk);
    flush      = 1'b0;
    resp_valid = 1'b0;
    chk("flush_wb_valid",
        {31'b0, wb_valid}, 32'd0);
    push(OP_LW, 2'd0, 32'h0, 5'd9);
    for (int k = 0; k < swallow; k++) begin
      resp_valid = 1'b1;
      resp_data  = 32'hBAD0_0000 + k;
      @(negedge clk);
      chk("swallow_wb_valid",
          {31'b0, wb_valid}, 32'd0);
    end
    resp_valid = 1'b1;
    resp_data  = 32'h4444_0009;
    @(negedge clk);
    resp_valid = 1'b0;
    chk("post_flush_wb_valid",
        {31'b0, wb_valid}, 32'd1);
    chk("post_flush_wb_data",
        wb_data, 32'h4444_0009);
    chk("post_flush_wb_dst",
        {27'b0, wb_dst}, 32'd9);
    @(negedge clk);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    v[0]  = '{OP_LB,  2'd3, 32'h80FF_FF7F, 32'h0,
              32'hFFFF_FF80};
    v[1]  = '{OP_LBU, 2'd3, 32'h80FF_FF7F, 32'h0,
              32'h0000_0080};
    v[2]  = '{OP_LB,  2'd0, 32'h80FF_FF7F, 32'h0,
              32'h0000_007F};
    v[3]  = '{OP_LH,  2'd1, 32'hBEEF_1234, 32'h0,
              32'h0000_1234};
    v[4]  = '{OP_LH,  2'd2, 32'hBEEF_1234, 32'h0,
              32'hFFFF_BEEF};
    v[5]  = '{OP_LHU, 2'd2, 32'hBEEF_1234, 32'h0,
              32'h0000_BEEF};
    v[6]  = '{OP_LW,  2'd0, 32'hAABB_CCDD, 32'h0,
              32'hAABB_CCDD};
    v[7]  = '{OP_LWL, 2'd0, 32'hAABB_CCDD,
              32'h1122_3344, 32'hDD22_3344};
    v[8]  = '{OP_LWL, 2'd1, 32'hAABB_CCDD,
              32'h1122_3344, 32'hCCDD_3344};
    v[9]  = '{OP_LWL, 2'd2, 32'hAABB_CCDD,
              32'h1122_3344, 32'hBBCC_DD44};
    v[10] = '{OP_LWL, 2'd3, 32'hAABB_CCDD,
              32'h1122_3344, 32'hAABB_CCDD};
    v[11] = '{OP_LWR, 2'd0, 32'hAABB_CCDD,
              32'h1122_3344, 32'hAABB_CCDD};
    v[12] = '{OP_LWR, 2'd1, 32'hAABB_CCDD,
              32'h1122_3344, 32'h11AA_BBCC};
    v[13] = '{OP_LWR, 2'd2, 32'hAABB_CCDD,
              32'h1122_3344, 32'h1122_AABB};
    v[14] = '{OP_LWR, 2'd3, 32'hAABB_CCDD,
              32'h1122_3344, 32'h1122_33AA};
    v[15] = '{OP_NOP, 2'd1, 32'h1357_9BDF, 32'h0,
              32'h1357_9BDF};
    v[16] = '{OP_LBU, 2'd1, 32'h0000_A500, 32'h0,
              32'h0000_00A5};

    resetn      = 1'b0;
    flush       = 1'b0;
    req_valid   = 1'b0;
    req_op      = OP_NOP;
    req_addr_lo = 2'd0;
    req_dst     = 5'd0;
    req_old     = 32'h0;
    resp_valid  = 1'b0;
    resp_data   = 32'h0;
    wb_ready    = 1'b1;
    #12;
    chk("rst_wb_valid", {31'b0, wb_valid}, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_wb_dst", {27'b0, wb_dst}, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    #1;
    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_resp_ready", {31'b0, resp_ready}, 32'd1);

    for (int i = 0; i < NV; i++)
      load_one(v[i].op, v[i].a, v[i].d, v[i].o,
               5'(i + 1), v[i].exp);
    @(negedge clk);
    chk("idle_wb_valid", {31'b0, wb_valid}, 32'd0);

    // Fill the queue, then backpressure writeback.
    wb_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      push(OP_LW, 2'd0, 32'h0, 5'(i + 1));
    chk("full_req_ready", {31'b0, req_ready}, 32'd0);
    resp_valid = 1'b1;
    resp_data  = 32'h0000_0101;
    #1;
    chk("full_pop_req_ready",
        {31'b0, req_ready}, 32'd0);
    @(negedge clk);
    resp_data = 32'h0000_0102;
    chk("bp_wb_valid", {31'b0, wb_valid}, 32'd1);
    chk("bp_resp_ready", {31'b0, resp_ready}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_hold_data", wb_data, 32'h0000_0101);
      chk("bp_hold_dst", {27'b0, wb_dst}, 32'd1);
      chk("bp_hold_valid", {31'b0, wb_valid}, 32'd1);
    end
    wb_ready = 1'b1;
    for (int k = 2; k <= 4; k++) begin
      @(negedge clk);
      chk("drain_valid", {31'b0, wb_valid}, 32'd1);
      chk("drain_data", wb_data, 32'h0000_0100 + k);
      chk("drain_dst", {27'b0, wb_dst}, 32'(k));
      resp_data = 32'h0000_0100 + k + 1;
      if (k == 4)
        resp_valid = 1'b0;
    end
    @(negedge clk);
    chk("drain_empty", {31'b0, wb_valid}, 32'd0);
    chk("drain_req_ready", {31'b0, req_ready}, 32'd1);

    flush_case(1'b0, 3);
    flush_case(1'b1, 2);

    chk("pre_orphan_err", {31'b0, err}, 32'd0);
    resp_valid = 1'b1;
    resp_data  = 32'h0BAD_BEEF;
    @(negedge clk);
    resp_valid = 1'b0;
    chk("orphan_wb_valid", {31'b0, wb_valid}, 32'd0);
    chk("orphan_err", {31'b0, err}, 32'd1);
    repeat (3) @(negedge clk);
    chk("orphan_err_sticky", {31'b0, err}, 32'd1);

    // Reset in the middle of traffic.
    wb_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      push(OP_LW, 2'd0, 32'h0, 5'(20 + i));
    resp_valid = 1'b1;
    resp_data  = 32'h7777_0020;
    @(negedge clk);
    resp_valid = 1'b0;
    chk("mid_wb_valid", {31'b0, wb_valid}, 32'd1);
    #2;
    resetn = 1'b0;
    #1;
    chk("arst_wb_valid", {31'b0, wb_valid}, 32'd0);
    chk("arst_wb_data", wb_data, 32'd0);
    chk("arst_wb_dst", {27'b0, wb_dst}, 32'd0);
    chk("arst_err", {31'b0, err}, 32'd0);
    @(negedge clk);
    resetn   = 1'b1;
    wb_ready = 1'b1;
    #1;
    chk("arst_req_ready", {31'b0, req_ready}, 32'd1);
    load_one(OP_LW, 2'd0, 32'hCAFE_F00D, 32'h0,
             5'd12, 32'hCAFE_F00D);
    chk("arst_err_after", {31'b0, err}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
